// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared timing constants for the pixel-timing generator.
//               Holds the 640x480@60 line/frame geometry, the derived
//               totals and the raster-position width used by every layer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   // Width of hpos/vpos as seen by the downstream layers.
   localparam int POS_W     = 10;
   localparam int POS_LIMIT = 1 << POS_W;

   // Horizontal geometry, in pixel ticks.
   localparam int H_ACTIVE  = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;

   // Vertical geometry, in lines.
   localparam int V_ACTIVE  = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis. A wrapping counter 0..TOTAL-1 that advances
//               when en is high, with a terminal-count flag and decodes of
//               the active and sync windows taken from the next count value,
//               so a register loaded from them lines up with the count.
// Ports       : clk, reset (async, active-high), en (advance enable)
//               count       - current position
//               terminal    - count == TOTAL-1
//               active_next - next count < ACTIVE
//               sync_next   - next count in [SYNC_START, SYNC_END)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int WIDTH      = POS_W,
   parameter int TOTAL      = H_TOTAL,
   parameter int ACTIVE     = H_ACTIVE,
   parameter int SYNC_START = H_ACTIVE + H_FP,
   parameter int SYNC_END   = H_ACTIVE + H_FP + H_SYNC
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             terminal,
   output logic             active_next,
   output logic             sync_next
);

   localparam logic [WIDTH-1:0] C_LAST       = WIDTH'(TOTAL - 1);
   localparam logic [WIDTH-1:0] C_ACTIVE     = WIDTH'(ACTIVE);
   localparam logic [WIDTH-1:0] C_SYNC_START = WIDTH'(SYNC_START);
   localparam logic [WIDTH-1:0] C_SYNC_END   = WIDTH'(SYNC_END);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;
   logic             w_terminal;

   assign w_terminal = (r_count == C_LAST);

   always_comb begin
      w_count_next = r_count;
      if (en) begin
         w_count_next = w_terminal ? '0 : r_count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign count       = r_count;
   assign terminal    = w_terminal;
   assign active_next = (w_count_next < C_ACTIVE);
   assign sync_next   = (w_count_next >= C_SYNC_START) && (w_count_next < C_SYNC_END);

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parameterised, clock-enabled raster timing generator.
//               Produces hpos/vpos, hsync/vsync, display_on, line/frame
//               start strobes and an 8-bit frame counter for the video
//               layers downstream.
// Ports       : clk         - pixel-domain clock
//               reset       - asynchronous, active-high reset
//               pix_en      - pixel tick enable
//               hpos, vpos  - raster position
//               display_on  - inside the visible area
//               hsync/vsync - SYNC_ACTIVE level inside the sync windows
//               line_start  - one-clock pulse when hpos wraps to 0
//               frame_start - one-clock pulse when (hpos,vpos) wraps to (0,0)
//               frame       - frame counter, wraps 255 -> 0
// Build macro : VGA_TIMING_SYNC_DELAY_EN - when defined, hsync/vsync and
//               display_on pass through one extra pix_en-qualified stage
//               and lag hpos/vpos by one pixel tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP        = vga_timing_pkg::H_FP,
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_BP        = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP        = vga_timing_pkg::V_FP,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_BP        = vga_timing_pkg::V_BP,
   parameter bit SYNC_ACTIVE = 1'b0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             display_on,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start,
   output logic [7:0]       frame
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Geometry that does not fit the position width is a build error.
   if (H_TOTAL > POS_LIMIT) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL exceeds the position range");
   end
   if (V_TOTAL > POS_LIMIT) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL exceeds the position range");
   end

   logic w_h_term, w_h_active_next, w_h_sync_next;
   logic w_v_term, w_v_active_next, w_v_sync_next;
   logic w_v_en;
   logic w_line_wrap, w_frame_wrap;

   logic       r_hsync, r_vsync, r_display_on;
   logic       r_line_start, r_frame_start;
   logic [7:0] r_frame;

   // Vertical axis advances only on the last pixel of a line.
   assign w_v_en       = pix_en & w_h_term;
   assign w_line_wrap  = pix_en & w_h_term;
   assign w_frame_wrap = w_line_wrap & w_v_term;

   vga_axis_counter #(
      .WIDTH      (POS_W),
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
   ) u_h_axis (
      .clk         (clk),
      .reset       (reset),
      .en          (pix_en),
      .count       (hpos),
      .terminal    (w_h_term),
      .active_next (w_h_active_next),
      .sync_next   (w_h_sync_next)
   );

   vga_axis_counter #(
      .WIDTH      (POS_W),
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
   ) u_v_axis (
      .clk         (clk),
      .reset       (reset),
      .en          (w_v_en),
      .count       (vpos),
      .terminal    (w_v_term),
      .active_next (w_v_active_next),
      .sync_next   (w_v_sync_next)
   );

   // Decoded outputs load from the next-state position so they describe the
   // same (hpos,vpos) that is visible in this cycle. After reset display_on
   // stays 0 at (0,0) until the first enabled tick. Strobes are cleared on
   // every cycle they are not firing, so a pulse is one clk wide even when
   // pix_en is only asserted intermittently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_display_on  <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame       <= 8'd0;
      end else begin
         r_line_start  <= w_line_wrap;
         r_frame_start <= w_frame_wrap;
         if (pix_en) begin
            r_hsync      <= w_h_sync_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync      <= w_v_sync_next ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_display_on <= w_h_active_next & w_v_active_next;
            if (w_frame_wrap) begin
               r_frame <= r_frame + 8'd1;
            end
         end
      end
   end

`ifdef VGA_TIMING_SYNC_DELAY_EN
   // One extra pixel-tick stage for layers that register rgb one cycle
   // after they see the position.
   logic r_hsync_d, r_vsync_d, r_display_on_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hsync_d      <= ~SYNC_ACTIVE;
         r_vsync_d      <= ~SYNC_ACTIVE;
         r_display_on_d <= 1'b0;
      end else if (pix_en) begin
         r_hsync_d      <= r_hsync;
         r_vsync_d      <= r_vsync;
         r_display_on_d <= r_display_on;
      end
   end

   assign hsync      = r_hsync_d;
   assign vsync      = r_vsync_d;
   assign display_on = r_display_on_d;
`else
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign display_on = r_display_on;
`endif

   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame       = r_frame;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Instance A uses the
//               default 640x480 geometry (line-level scenarios); instance B
//               uses a tiny 8x6 raster with active-high sync so that whole
//               frames and the 8-bit frame wrap fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
   localparam bit DLY = 1'b1;
`else
   localparam bit DLY = 1'b0;
`endif

   // Tiny raster for instance B: H 4+1+2+1 = 8, V 3+1+1+1 = 6.
   localparam int BH_TOT = 8;
   localparam int BV_TOT = 6;
   localparam int B_FRAME_TICKS = BH_TOT * BV_TOT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, rst_b, en_b;
   logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
   logic       de_a, hs_a, vs_a, ls_a, fs_a;
   logic       de_b, hs_b, vs_b, ls_b, fs_b;
   logic [7:0] frame_a, frame_b;

   vga_timing_gen dut_a (
      .clk(clk), .reset(rst_a), .pix_en(en_a),
      .hpos(hpos_a), .vpos(vpos_a), .display_on(de_a),
      .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
      .frame_start(fs_a), .frame(frame_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE(1'b1)
   ) dut_b (
      .clk(clk), .reset(rst_b), .pix_en(en_b),
      .hpos(hpos_b), .vpos(vpos_b), .display_on(de_b),
      .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
      .frame_start(fs_b), .frame(frame_b)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int   t;    // enabled ticks since reset release
      logic hs;
      logic de;
      logic ls;
      logic fs;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   idx, ls_cnt, fs_cnt;
      int   pulses, first_pulse, period, hold_err, width_err;
      logic prev_ls, prev_hs, prev_de;
      logic [9:0] prev_h;
      int   mh, mv, mf, bfs_cnt;
      logic e_ls, e_fs, ud_hs, ud_vs, ud_de, r_hs, r_vs, r_de, x_hs, x_vs, x_de;

      // Expected first-line checkpoints for instance A.
      if (DLY) begin
         tbl[0] = '{1,   1'b1, 1'b0, 1'b0, 1'b0};
         tbl[1] = '{2,   1'b1, 1'b1, 1'b0, 1'b0};
         tbl[2] = '{640, 1'b1, 1'b1, 1'b0, 1'b0};
         tbl[3] = '{641, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[4] = '{656, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[5] = '{657, 1'b0, 1'b0, 1'b0, 1'b0};
         tbl[6] = '{752, 1'b0, 1'b0, 1'b0, 1'b0};
         tbl[7] = '{753, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[8] = '{800, 1'b1, 1'b0, 1'b1, 1'b0};
         tbl[9] = '{801, 1'b1, 1'b1, 1'b0, 1'b0};
      end else begin
         tbl[0] = '{1,   1'b1, 1'b1, 1'b0, 1'b0};
         tbl[1] = '{639, 1'b1, 1'b1, 1'b0, 1'b0};
         tbl[2] = '{640, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[3] = '{655, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[4] = '{656, 1'b0, 1'b0, 1'b0, 1'b0};
         tbl[5] = '{751, 1'b0, 1'b0, 1'b0, 1'b0};
         tbl[6] = '{752, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[7] = '{799, 1'b1, 1'b0, 1'b0, 1'b0};
         tbl[8] = '{800, 1'b1, 1'b1, 1'b1, 1'b0};
         tbl[9] = '{801, 1'b1, 1'b1, 1'b0, 1'b0};
      end

      // ---------------- Reset state, instance A ----------------
      rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b0;
      repeat (3) tick();
      check("rst_hpos",  hpos_a,  0);
      check("rst_vpos",  vpos_a,  0);
      check("rst_frame", frame_a, 0);
      check("rst_de",    de_a,    0);
      check("rst_hsync", hs_a,    1);
      check("rst_vsync", vs_a,    1);
      check("rst_ls",    ls_a,    0);
      check("rst_fs",    fs_a,    0);

      // ---------------- First line, table driven ----------------
      rst_a  = 1'b0;
      idx    = 0;
      ls_cnt = 0;
      fs_cnt = 0;
      for (int t = 1; t <= 801; t++) begin
         tick();
         if (t <= 800 && ls_a) ls_cnt++;
         if (fs_a) fs_cnt++;
         if (idx < 10 && tbl[idx].t == t) begin
            check($sformatf("line0_hpos[t=%0d]", t), hpos_a, t % 800);
            check($sformatf("line0_vpos[t=%0d]", t), vpos_a, t / 800);
            check($sformatf("line0_hsync[t=%0d]", t), hs_a, tbl[idx].hs);
            check($sformatf("line0_de[t=%0d]", t), de_a, tbl[idx].de);
            check($sformatf("line0_ls[t=%0d]", t), ls_a, tbl[idx].ls);
            check($sformatf("line0_fs[t=%0d]", t), fs_a, tbl[idx].fs);
            idx++;
         end
      end
      check("line0_ls_count", ls_cnt, 1);
      check("line0_fs_count", fs_cnt, 0);
      check("line0_vsync",    vs_a,   1);

      // ---------------- pix_en every other clk ----------------
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      pulses = 0; first_pulse = -1; period = -1; hold_err = 0; width_err = 0;
      prev_ls = ls_a;
      for (int c = 0; c < 3400; c++) begin
         en_a    = (c % 2 == 0);
         prev_h  = hpos_a;
         prev_hs = hs_a;
         prev_de = de_a;
         tick();
         if (!en_a && (hpos_a != prev_h || hs_a != prev_hs || de_a != prev_de)) hold_err++;
         if (ls_a) begin
            if (prev_ls) width_err++;
            if (pulses == 0) first_pulse = c;
            else if (pulses == 1) period = c - first_pulse;
            pulses++;
         end
         prev_ls = ls_a;
      end
      check("toggle_pulses",      pulses,      2);
      check("toggle_first_pulse", first_pulse, 1598);
      check("toggle_period",      period,      1600);
      check("toggle_hold_err",    hold_err,    0);
      check("toggle_width_err",   width_err,   0);

      // ---------------- Asynchronous reset mid-line ----------------
      rst_a = 1'b1; en_a = 1'b1; tick(); rst_a = 1'b0;
      repeat (1100) tick();
      check("mid_hpos", hpos_a, 300);
      check("mid_vpos", vpos_a, 1);
      #2;
      rst_a = 1'b1;
      #1;
      check("async_hpos",  hpos_a,  0);
      check("async_vpos",  vpos_a,  0);
      check("async_frame", frame_a, 0);
      check("async_hsync", hs_a,    1);
      check("async_vsync", vs_a,    1);
      check("async_de",    de_a,    0);
      tick();
      rst_a = 1'b0;
      tick();
      check("recover_hpos", hpos_a, 1);
      check("recover_de",   de_a,   DLY ? 0 : 1);
      check("recover_ls",   ls_a,   0);

      // ---------------- Instance B: whole frames and frame wrap ----------------
      rst_a = 1'b1;
      rst_b = 1'b1; en_b = 1'b1;
      tick();
      check("b_rst_hsync", hs_b,    0);
      check("b_rst_vsync", vs_b,    0);
      check("b_rst_de",    de_b,    0);
      check("b_rst_frame", frame_b, 0);
      rst_b = 1'b0;
      mh = 0; mv = 0; mf = 0; bfs_cnt = 0;
      r_hs = 1'b0; r_vs = 1'b0; r_de = 1'b0;   // undelayed registers after reset
      for (int t = 1; t <= 256 * B_FRAME_TICKS + 8; t++) begin
         tick();
         e_ls = 1'b0; e_fs = 1'b0;
         if (mh == BH_TOT - 1) begin
            mh = 0; e_ls = 1'b1;
            if (mv == BV_TOT - 1) begin
               mv = 0; e_fs = 1'b1; mf = (mf + 1) % 256;
            end else begin
               mv++;
            end
         end else begin
            mh++;
         end
         ud_hs = (mh >= 5 && mh < 7);
         ud_vs = (mv == 4);
         ud_de = (mh < 4 && mv < 3);
         x_hs = DLY ? r_hs : ud_hs;
         x_vs = DLY ? r_vs : ud_vs;
         x_de = DLY ? r_de : ud_de;
         r_hs = ud_hs; r_vs = ud_vs; r_de = ud_de;
         if (fs_b) bfs_cnt++;
         check($sformatf("b_tick[t=%0d]", t),
               {hpos_b, vpos_b, frame_b, hs_b, vs_b, de_b, ls_b, fs_b},
               {10'(mh), 10'(mv), 8'(mf), x_hs, x_vs, x_de, e_ls, e_fs});
         if (t == B_FRAME_TICKS)        check("b_frame_1",   frame_b, 1);
         if (t == 2 * B_FRAME_TICKS)    check("b_frame_2",   frame_b, 2);
         if (t == 255 * B_FRAME_TICKS)  check("b_frame_255", frame_b, 255);
         if (t == 256 * B_FRAME_TICKS)  check("b_frame_wrap", frame_b, 0);
      end
      check("b_fs_count", bfs_cnt, 256);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_vga_timing_gen
`default_nettype wire
